// File: rtl/cvxif_offload_queue.sv
// In-order offload buffer between the issue stage and the CV-X-IF issue channel.
// It assigns transaction IDs and caps the number of issued instructions that still await a result.
module cvxif_offload_queue #(
    parameter int unsigned XLEN            = 32,  // core XLEN in this configuration
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned ID_WIDTH        = 3,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic                               req_valid_i,
    output logic                               req_ready_o,
    input  logic [31:0]                        req_instr_i,
    input  logic [XLEN-1:0]                    req_rs1_i,
    input  logic [XLEN-1:0]                    req_rs2_i,
    output logic [ID_WIDTH-1:0]                req_id_o,
    output logic                               x_issue_valid_o,
    input  logic                               x_issue_ready_i,
    output logic [31:0]                        x_issue_instr_o,
    output logic [XLEN-1:0]                    x_issue_rs1_o,
    output logic [XLEN-1:0]                    x_issue_rs2_o,
    output logic [ID_WIDTH-1:0]                x_issue_id_o,
    input  logic                               x_result_valid_i,
    output logic [$clog2(DEPTH):0]             count_o,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [OW-1:0] MAX_C   = OW'(MAX_OUTSTANDING);

    logic [31:0]          instr_q [DEPTH];
    logic [XLEN-1:0]      rs1_q   [DEPTH];
    logic [XLEN-1:0]      rs2_q   [DEPTH];
    logic [ID_WIDTH-1:0]  id_q    [DEPTH];

    logic [AW-1:0]        head_q, head_d, tail_q, tail_d;
    logic [AW:0]          count_q, count_d;
    logic [ID_WIDTH-1:0]  next_id_q, next_id_d;
    logic [OW-1:0]        outstanding_q, outstanding_d;
    logic                 accept_s, fire_s, retire_s, head_locked_out_s;

    // Handshake qualifiers and the issue-side view of the head entry.
    always_comb begin
        // A reset cycle must not hand the coprocessor an entry that is about to vanish.
        head_locked_out_s = rst_i;
        req_ready_o       = (count_q < DEPTH_C) && !flush_i;
        x_issue_valid_o   = (count_q != '0) && (outstanding_q < MAX_C) && !head_locked_out_s;
        accept_s          = req_valid_i && req_ready_o;
        fire_s            = x_issue_valid_o && x_issue_ready_i;
        retire_s          = x_result_valid_i && (outstanding_q != '0);
        req_id_o          = next_id_q;
        x_issue_instr_o   = instr_q[head_q];
        x_issue_rs1_o     = rs1_q[head_q];
        x_issue_rs2_o     = rs2_q[head_q];
        x_issue_id_o      = id_q[head_q];
        count_o           = count_q;
        outstanding_o     = outstanding_q;
    end

    // Next-state for pointers, occupancy, ID counter and outstanding counter.
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        next_id_d     = next_id_q;
        outstanding_d = outstanding_q;

        if (flush_i) begin
            if (x_issue_valid_o && !fire_s) begin
                // The presented head survives alone so the issue channel stays stable.
                tail_d  = head_q + AW'(1);
                count_d = (AW+1)'(1);
            end else begin
                head_d  = fire_s ? head_q + AW'(1) : head_q;
                tail_d  = head_d;
                count_d = '0;
            end
        end else begin
            if (fire_s) begin
                head_d = head_q + AW'(1);
            end else begin
                head_d = head_q;
            end
            if (accept_s) begin
                tail_d = tail_q + AW'(1);
            end else begin
                tail_d = tail_q;
            end
            case ({accept_s, fire_s})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end

        if (accept_s) begin
            next_id_d = next_id_q + ID_WIDTH'(1);
        end else begin
            next_id_d = next_id_q;
        end

        case ({fire_s, retire_s})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            next_id_q     <= '0;
            outstanding_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            next_id_q     <= next_id_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Payload storage, written at the tail on accept and never reset.
    always_ff @(posedge clk_i) begin
        if (accept_s) begin
            instr_q[tail_q] <= req_instr_i;
            rs1_q[tail_q]   <= req_rs1_i;
            rs2_q[tail_q]   <= req_rs2_i;
            id_q[tail_q]    <= next_id_q;
        end
    end

    cvxif_offload_queue_checker #(
        .OW (OW)
    ) u_checker (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .x_result_valid_i (x_result_valid_i),
        .outstanding_i    (outstanding_q)
    );
endmodule

// Protocol checks on the coprocessor side of the queue.
module cvxif_offload_queue_checker #(
    parameter int unsigned OW = 3
) (
    input logic          clk_i,
    input logic          rst_i,
    input logic          x_result_valid_i,
    input logic [OW-1:0] outstanding_i
);
    // A result with nothing outstanding is a coprocessor protocol error; the queue ignores it.
    a_result_without_outstanding: assert property (
        @(posedge clk_i) disable iff (rst_i) !(x_result_valid_i && (outstanding_i == '0))
    );
endmodule
